// File: rtl/uart_interface.sv
`timescale 1ns/1ps
// uart_interface
// Full-duplex 8N1 UART: start bit 0, 8 data bits LSB first, stop bit 1,
// each bit CLKS_PER_BIT system clocks long. TX and RX run independently.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   transmit   request to send TxData (ignored while a frame is in flight)
//   TxData     byte to transmit, latched when the request is accepted
//   TxD        serial transmit line, idle high
//   tx_busy    high while a frame is being sent
//   tx_done    one-cycle pulse after the stop bit completes
//   RxD        serial receive line, asynchronous to clk
//   RxData     last correctly received byte
//   rx_valid   one-cycle pulse when RxData updates
//   frame_err  one-cycle pulse when a received stop bit is 0
module uart_interface #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       transmit,
    input  logic [7:0] TxData,
    output logic       TxD,
    output logic       tx_busy,
    output logic       tx_done,
    input  logic       RxD,
    output logic [7:0] RxData,
    output logic       rx_valid,
    output logic       frame_err
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // ---------------------------------------------------------------- TX
    tx_state_t        r_tx_state, w_tx_state_nx;
    logic [CNT_W-1:0] r_tx_cnt,   w_tx_cnt_nx;
    logic [7:0]       r_tx_shift, w_tx_shift_nx;
    logic [2:0]       r_tx_bit,   w_tx_bit_nx;
    logic             r_txd, r_tx_busy, r_tx_done;
    logic             w_tx_last;

    assign w_tx_last = (r_tx_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_shift <= '0;
            r_tx_bit   <= '0;
        end else begin
            r_tx_state <= w_tx_state_nx;
            r_tx_cnt   <= w_tx_cnt_nx;
            r_tx_shift <= w_tx_shift_nx;
            r_tx_bit   <= w_tx_bit_nx;
        end
    end

    always_comb begin
        w_tx_state_nx = r_tx_state;
        w_tx_cnt_nx   = r_tx_cnt;
        w_tx_shift_nx = r_tx_shift;
        w_tx_bit_nx   = r_tx_bit;
        case (r_tx_state)
            TX_IDLE: begin
                if (transmit) begin
                    w_tx_shift_nx = TxData;
                    w_tx_cnt_nx   = '0;
                    w_tx_bit_nx   = '0;
                    w_tx_state_nx = TX_START;
                end
            end
            TX_START: begin
                w_tx_cnt_nx = r_tx_cnt + CNT_W'(1);
                if (w_tx_last) begin
                    w_tx_cnt_nx   = '0;
                    w_tx_state_nx = TX_DATA;
                end
            end
            TX_DATA: begin
                w_tx_cnt_nx = r_tx_cnt + CNT_W'(1);
                if (w_tx_last) begin
                    w_tx_cnt_nx   = '0;
                    w_tx_shift_nx = r_tx_shift >> 1;
                    w_tx_bit_nx   = r_tx_bit + 3'd1;
                    if (r_tx_bit == 3'd7) begin
                        w_tx_state_nx = TX_STOP;
                    end
                end
            end
            TX_STOP: begin
                w_tx_cnt_nx = r_tx_cnt + CNT_W'(1);
                if (w_tx_last) begin
                    w_tx_cnt_nx   = '0;
                    w_tx_state_nx = TX_IDLE;
                end
            end
            default: w_tx_state_nx = TX_IDLE;
        endcase
    end

    // Line outputs are registered from the state, so the pin view trails the
    // FSM by one cycle: request at edge N shows on TxD/tx_busy from edge N+1.
    // tx_done fires on the first cycle the FSM is back in IDLE with busy
    // still set, which is also the edge a held request re-starts the FSM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_txd     <= 1'b1;
            r_tx_busy <= 1'b0;
            r_tx_done <= 1'b0;
        end else begin
            r_tx_busy <= (r_tx_state != TX_IDLE);
            r_tx_done <= r_tx_busy && (r_tx_state == TX_IDLE);
            case (r_tx_state)
                TX_START: r_txd <= 1'b0;
                TX_DATA:  r_txd <= r_tx_shift[0];
                default:  r_txd <= 1'b1;
            endcase
        end
    end

    assign TxD     = r_txd;
    assign tx_busy = r_tx_busy;
    assign tx_done = r_tx_done;

    // ---------------------------------------------------------------- RX
    rx_state_t        r_rx_state, w_rx_state_nx;
    logic [CNT_W-1:0] r_rx_cnt,   w_rx_cnt_nx;
    logic [7:0]       r_rx_shift, w_rx_shift_nx;
    logic [2:0]       r_rx_bit,   w_rx_bit_nx;
    logic             r_rx_meta, r_rx_sync, r_rx_prev;
    logic [7:0]       r_rx_data;
    logic             r_rx_valid, r_frame_err;
    logic             w_rx_last, w_rx_stop_sample;

    assign w_rx_last        = (r_rx_cnt == CNT_LAST);
    assign w_rx_stop_sample = (r_rx_state == RX_STOP) && w_rx_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_shift <= '0;
            r_rx_bit   <= '0;
        end else begin
            r_rx_meta  <= RxD;
            r_rx_sync  <= r_rx_meta;
            r_rx_prev  <= r_rx_sync;
            r_rx_state <= w_rx_state_nx;
            r_rx_cnt   <= w_rx_cnt_nx;
            r_rx_shift <= w_rx_shift_nx;
            r_rx_bit   <= w_rx_bit_nx;
        end
    end

    // START counts to the start-bit centre; from there every bit is sampled
    // a full bit period later, so all samples land at bit centres.
    always_comb begin
        w_rx_state_nx = r_rx_state;
        w_rx_cnt_nx   = r_rx_cnt;
        w_rx_shift_nx = r_rx_shift;
        w_rx_bit_nx   = r_rx_bit;
        case (r_rx_state)
            RX_IDLE: begin
                if (!r_rx_sync && r_rx_prev) begin
                    w_rx_cnt_nx   = '0;
                    w_rx_state_nx = RX_START;
                end
            end
            RX_START: begin
                w_rx_cnt_nx = r_rx_cnt + CNT_W'(1);
                if (r_rx_cnt == CNT_HALF) begin
                    w_rx_cnt_nx   = '0;
                    w_rx_bit_nx   = '0;
                    w_rx_state_nx = r_rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                w_rx_cnt_nx = r_rx_cnt + CNT_W'(1);
                if (w_rx_last) begin
                    w_rx_cnt_nx   = '0;
                    w_rx_shift_nx = {r_rx_sync, r_rx_shift[7:1]};
                    w_rx_bit_nx   = r_rx_bit + 3'd1;
                    if (r_rx_bit == 3'd7) begin
                        w_rx_state_nx = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                w_rx_cnt_nx = r_rx_cnt + CNT_W'(1);
                if (w_rx_last) begin
                    w_rx_cnt_nx   = '0;
                    w_rx_state_nx = RX_IDLE;
                end
            end
            default: w_rx_state_nx = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_rx_stop_sample) begin
                if (r_rx_sync) begin
                    r_rx_data  <= r_rx_shift;
                    r_rx_valid <= 1'b1;
                end else begin
                    r_frame_err <= 1'b1;
                end
            end
        end
    end

    assign RxData    = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_interface.sv
`timescale 1ns/1ps
// tb_uart_interface
// Loopback bench for uart_interface with a short bit period. Received bytes
// are checked against a scoreboard queue filled when each byte is requested;
// pin-level timing and error handling are checked by hand-written sequences.
module tb_uart_interface;
    localparam int C = 16;

    logic       clk;
    logic       reset;
    logic       transmit;
    logic [7:0] TxData;
    logic       TxD;
    logic       tx_busy;
    logic       tx_done;
    logic       RxD;
    logic [7:0] RxData;
    logic       rx_valid;
    logic       frame_err;

    logic       loop_en;
    logic       drv_rxd;

    assign RxD = loop_en ? TxD : drv_rxd;

    uart_interface #(.CLKS_PER_BIT(C)) dut (
        .clk       (clk),
        .reset     (reset),
        .transmit  (transmit),
        .TxData    (TxData),
        .TxD       (TxD),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .RxD       (RxD),
        .RxData    (RxData),
        .rx_valid  (rx_valid),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_rx   = 0;
    int n_ferr = 0;
    int n_done = 0;
    int n_push = 0;
    logic [7:0] sb[$];
    logic [7:0] exp_last;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] exp_rx;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        sb.push_back(d);
        n_push++;
        exp_last = d;
    endtask

    // Called at a negedge; returns at the negedge where tx_done is seen.
    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (tx_done !== 1'b1 && k < 12 * C + 20) begin
            @(negedge clk);
            k++;
        end
        if (tx_done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s: tx_done not seen within %0d cycles", name, k);
        end
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, d, 1'b0};
        @(negedge clk);
        for (int j = 0; j < 10; j++) begin
            drv_rxd = f[j];
            repeat (C) @(negedge clk);
        end
        drv_rxd = 1'b1;
    endtask

    // Scoreboard monitor: every rx_valid pops one expected byte.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            n_rx++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected: got %02h expected no byte", RxData);
            end else begin
                check("rx_data", {24'h0, RxData}, {24'h0, sb.pop_front()});
            end
        end
        if (frame_err === 1'b1) n_ferr++;
        if (tx_done === 1'b1) n_done++;
    end

    initial begin
        logic [9:0] frame;
        int r0, f0, d0, cyc;

        vecs[0] = '{tx: 8'h00, exp_rx: 8'h00};
        vecs[1] = '{tx: 8'hFF, exp_rx: 8'hFF};
        vecs[2] = '{tx: 8'h3C, exp_rx: 8'h3C};
        vecs[3] = '{tx: 8'hC3, exp_rx: 8'hC3};

        reset    = 1'b0;
        transmit = 1'b0;
        TxData   = 8'h00;
        loop_en  = 1'b1;
        drv_rxd  = 1'b1;
        exp_last = 8'h00;

        // Reset state
        #50;
        check("rst_txd",      {31'h0, TxD},       32'h1);
        check("rst_busy",     {31'h0, tx_busy},   32'h0);
        check("rst_done",     {31'h0, tx_done},   32'h0);
        check("rst_rxvalid",  {31'h0, rx_valid},  32'h0);
        check("rst_ferr",     {31'h0, frame_err}, 32'h0);
        check("rst_rxdata",   {24'h0, RxData},    32'h0);
        #50 reset = 1'b1;
        repeat (5 * C) @(negedge clk);
        check("idle_txd",  {31'h0, TxD},     32'h1);
        check("idle_busy", {31'h0, tx_busy}, 32'h0);
        check("idle_activity", n_rx + n_ferr + n_done, 0);

        // Loopback 0xA5 with pin-level timing
        frame = {1'b1, 8'hA5, 1'b0};
        @(negedge clk);
        TxData   = 8'hA5;
        transmit = 1'b1;
        push(8'hA5);
        @(posedge clk);                 // edge N: request sampled
        #1;
        check("a5_txd_at_N",  {31'h0, TxD},     32'h1);
        check("a5_busy_at_N", {31'h0, tx_busy}, 32'h0);
        TxData = 8'h00;                 // must not disturb the frame in flight
        @(negedge clk);
        transmit = 1'b0;
        @(posedge clk);                 // edge N+1
        #1;
        check("a5_busy_N1", {31'h0, tx_busy}, 32'h1);
        check("a5_txd_N1",  {31'h0, TxD},     32'h0);
        for (int j = 0; j < 10; j++) begin
            repeat (C / 2) @(posedge clk);
            #1;
            check($sformatf("a5_bit%0d", j), {31'h0, TxD}, {31'h0, frame[j]});
            repeat (C - C / 2) @(posedge clk);
        end
        #1;                             // edge N+1+10C
        check("a5_done_pulse", {31'h0, tx_done}, 32'h1);
        check("a5_busy_fall",  {31'h0, tx_busy}, 32'h0);
        check("a5_txd_stop",   {31'h0, TxD},     32'h1);
        check("a5_rx_first",   {24'h0, RxData},  32'hA5);
        @(posedge clk);
        #1;
        check("a5_done_width", {31'h0, tx_done}, 32'h0);

        // Back-to-back table, next request issued on each tx_done
        r0 = n_rx;
        f0 = n_ferr;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            TxData   = vecs[i].tx;
            transmit = 1'b1;
            push(vecs[i].exp_rx);
            @(negedge clk);
            transmit = 1'b0;
            wait_done($sformatf("b2b_%0d", i));
            check($sformatf("b2b_rxdata_%0d", i), {24'h0, RxData}, {24'h0, vecs[i].exp_rx});
        end
        repeat (2) @(negedge clk);
        check("b2b_rx_count", n_rx - r0, 4);
        check("b2b_no_ferr",  n_ferr - f0, 0);

        // Transmit held high: frames repeat every 10C+1 cycles
        repeat (3) @(negedge clk);
        TxData   = 8'h11;
        transmit = 1'b1;
        push(8'h11);
        @(negedge clk);
        TxData = 8'h22;
        wait_done("held_first");
        push(8'h22);
        transmit = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (tx_done !== 1'b1 && cyc < 12 * C + 20);
        check("held_period", cyc, 10 * C + 1);

        // Request while busy is ignored
        repeat (4) @(negedge clk);
        d0 = n_done;
        TxData   = 8'h55;
        transmit = 1'b1;
        push(8'h55);
        @(negedge clk);
        transmit = 1'b0;
        repeat (3 * C) @(negedge clk);
        TxData   = 8'h12;
        transmit = 1'b1;
        @(negedge clk);
        transmit = 1'b0;
        wait_done("busy_ignore");
        repeat (12 * C) @(negedge clk);
        check("busy_one_done", n_done - d0, 1);
        check("busy_idle",     {31'h0, tx_busy}, 32'h0);
        check("busy_rxdata",   {24'h0, RxData},  32'h55);

        // Framing error, glitch, then a clean externally driven frame
        drv_rxd = 1'b1;
        loop_en = 1'b0;
        repeat (4) @(negedge clk);
        r0 = n_rx;
        f0 = n_ferr;
        drive_frame(8'h81, 1'b0);
        repeat (2 * C) @(negedge clk);
        check("ferr_pulse",   n_ferr - f0, 1);
        check("ferr_no_rx",   n_rx - r0, 0);
        check("ferr_rxdata",  {24'h0, RxData}, {24'h0, exp_last});
        drv_rxd = 1'b0;
        repeat (C / 4) @(negedge clk);
        drv_rxd = 1'b1;
        repeat (12 * C) @(negedge clk);
        check("glitch_no_rx",   n_rx - r0, 0);
        check("glitch_no_ferr", n_ferr - f0, 1);
        push(8'h81);
        drive_frame(8'h81, 1'b1);
        repeat (2 * C) @(negedge clk);
        check("ext_rx_count", n_rx - r0, 1);
        check("ext_rxdata",   {24'h0, RxData}, 32'h81);

        // Reset during data bit 4 of 0xF0
        loop_en = 1'b1;
        repeat (4) @(negedge clk);
        TxData   = 8'hF0;
        transmit = 1'b1;
        @(negedge clk);
        transmit = 1'b0;
        repeat (5 * C + C / 2) @(negedge clk);
        check("mid_busy_before", {31'h0, tx_busy}, 32'h1);
        #3 reset = 1'b0;
        #1;
        check("mid_rst_txd",    {31'h0, TxD},     32'h1);
        check("mid_rst_busy",   {31'h0, tx_busy}, 32'h0);
        check("mid_rst_rxdata", {24'h0, RxData},  32'h0);
        exp_last = 8'h00;
        #100 reset = 1'b1;
        @(negedge clk);
        TxData   = 8'h0F;
        transmit = 1'b1;
        push(8'h0F);
        @(negedge clk);
        transmit = 1'b0;
        wait_done("after_reset");
        check("after_reset_rxdata", {24'h0, RxData}, 32'h0F);

        repeat (4) @(negedge clk);
        check("sb_empty",    sb.size(), 0);
        check("rx_total",    n_rx, n_push);
        check("ferr_total",  n_ferr, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
